// File: rtl/alu_share_scheduler_pkg.sv
// Shared definitions for the two-requester add/subtract scheduler.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package alu_share_scheduler_pkg;

  // Operation encodings carried on req_op.
  localparam logic ALU_OP_ADD = 1'b0;
  localparam logic ALU_OP_SUB = 1'b1;

  // Bit positions inside rsp_cc = {ZF, SF, OF}.
  localparam int CC_ZF = 2;
  localparam int CC_SF = 1;
  localparam int CC_OF = 0;

  // Scheduler FSM states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/alu_addsub_core.sv
// Shared combinational adder/subtractor with signed-overflow detect.
// Latency: 0 cycles (purely combinational).
// Backpressure: none; the caller owns sequencing.
module alu_addsub_core
  import alu_share_scheduler_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             of
);

  // Modulo-2^WIDTH add or subtract; carry out is simply not kept.
  always_comb begin
    result = '0;
    of     = 1'b0;
    if (op == ALU_OP_SUB) begin
      result = a - b;
      of     = (a[WIDTH-1] != b[WIDTH-1]) && (result[WIDTH-1] != a[WIDTH-1]);
    end else begin
      result = a + b;
      of     = (a[WIDTH-1] == b[WIDTH-1]) && (result[WIDTH-1] != a[WIDTH-1]);
    end
  end

endmodule

// File: rtl/alu_share_scheduler.sv
// Arbitrates two requesters onto one add/sub core (IDLE->EXEC->RESP); ALU_SHARE_RR_EN selects round-robin, else fixed priority to requester 0.
// Latency: accept at edge N, rsp_valid visible after edge N+1; one op per 3 cycles with rsp_ready high.
// Backpressure: RESP holds stable outputs until rsp_ready; req_ready stays low outside IDLE.
module alu_share_scheduler
  import alu_share_scheduler_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int NREQ  = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ-1:0]       req_op,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_id,
  output logic [WIDTH-1:0]      rsp_result,
  output logic [2:0]            rsp_cc
);

  state_t           state;
  state_t           state_nxt;
  logic             any_vld;
  logic             accept;
  logic             gnt_id;

  logic             cap_op;
  logic             cap_id;
  logic [WIDTH-1:0] cap_a;
  logic [WIDTH-1:0] cap_b;

  logic [WIDTH-1:0] core_result;
  logic             core_of;
  logic [2:0]       cc_nxt;

  assign any_vld = |req_valid;
  // A grant in IDLE is always accepted: ready is only raised toward a valid requester.
  assign accept  = (state == ST_IDLE) && any_vld;

`ifdef ALU_SHARE_RR_EN
  // Requester that wins the next tie; flips away from whoever was just served.
  logic prio;

  // Tie goes to the pointer; a lone requester wins regardless.
  always_comb begin
    gnt_id = req_valid[1];
    if (&req_valid) begin
      gnt_id = prio;
    end
  end

  // Advance the pointer on every accepted request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio <= 1'b0;
    end else if (accept) begin
      prio <= ~gnt_id;
    end
  end
`else
  // Requester 0 always wins when it is valid.
  always_comb begin
    gnt_id = ~req_valid[0];
  end
`endif

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and grant strobe; ready is masked while reset is held.
  always_comb begin
    state_nxt = state;
    req_ready = '0;
    case (state)
      ST_IDLE: begin
        if (any_vld) begin
          req_ready = {gnt_id, ~gnt_id} & {NREQ{rst_n}};
          state_nxt = ST_EXEC;
        end
      end
      ST_EXEC: begin
        state_nxt = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  assign rsp_valid = (state == ST_RESP);

  // Capture the granted requester's operation and operands on acceptance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_op <= ALU_OP_ADD;
      cap_id <= 1'b0;
      cap_a  <= '0;
      cap_b  <= '0;
    end else if (accept) begin
      cap_op <= gnt_id ? req_op[1] : req_op[0];
      cap_id <= gnt_id;
      cap_a  <= gnt_id ? req_a[2*WIDTH-1:WIDTH] : req_a[WIDTH-1:0];
      cap_b  <= gnt_id ? req_b[2*WIDTH-1:WIDTH] : req_b[WIDTH-1:0];
    end
  end

  alu_addsub_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .op     (cap_op),
    .a      (cap_a),
    .b      (cap_b),
    .result (core_result),
    .of     (core_of)
  );

  // Assemble {ZF, SF, OF} from the core output.
  always_comb begin
    cc_nxt        = '0;
    cc_nxt[CC_ZF] = (core_result == '0);
    cc_nxt[CC_SF] = core_result[WIDTH-1];
    cc_nxt[CC_OF] = core_of;
  end

  // Register the response in EXEC; it then holds through RESP untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_id     <= 1'b0;
      rsp_result <= '0;
      rsp_cc     <= '0;
    end else if (state == ST_EXEC) begin
      rsp_id     <= cap_id;
      rsp_result <= core_result;
      rsp_cc     <= cc_nxt;
    end
  end

endmodule

// File: tb/tb_alu_share_scheduler.sv
// Directed self-checking bench for alu_share_scheduler.
// Latency: n/a.
// Backpressure: exercises rsp_ready stalls and simultaneous requesters.
module tb_alu_share_scheduler;

  localparam int WIDTH = 64;

  logic               clk;
  logic               rst_n;
  logic [1:0]         req_valid;
  logic [1:0]         req_ready;
  logic [1:0]         req_op;
  logic [2*WIDTH-1:0] req_a;
  logic [2*WIDTH-1:0] req_b;
  logic               rsp_valid;
  logic               rsp_ready;
  logic               rsp_id;
  logic [WIDTH-1:0]   rsp_result;
  logic [2:0]         rsp_cc;

  int checks = 0;
  int errors = 0;

  alu_share_scheduler #(
    .WIDTH (WIDTH),
    .NREQ  (2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_a      (req_a),
    .req_b      (req_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
    .rsp_cc     (rsp_cc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Single op from one requester with rsp_ready high; starts and ends at a negedge in IDLE.
  task automatic do_op(input string tag, input bit id, input bit op,
                       input logic [63:0] a, input logic [63:0] b,
                       input logic [63:0] exp_res, input logic [2:0] exp_cc);
    @(negedge clk);
    req_valid  = id ? 2'b10 : 2'b01;
    req_op[id] = op;
    if (id) begin
      req_a[127:64] = a;
      req_b[127:64] = b;
    end else begin
      req_a[63:0] = a;
      req_b[63:0] = b;
    end
    #1;
    check({tag, "_grant"}, 64'(req_ready), id ? 64'd2 : 64'd1);
    @(negedge clk);
    req_valid = 2'b00;
    check({tag, "_exec_vld"}, 64'(rsp_valid), 64'd0);
    check({tag, "_exec_rdy"}, 64'(req_ready), 64'd0);
    @(negedge clk);
    check({tag, "_rsp_vld"}, 64'(rsp_valid), 64'd1);
    check({tag, "_rsp_id"}, 64'(rsp_id), 64'(id));
    check({tag, "_result"}, rsp_result, exp_res);
    check({tag, "_cc"}, 64'(rsp_cc), 64'(exp_cc));
    @(negedge clk);
    check({tag, "_done"}, 64'(rsp_valid), 64'd0);
  endtask

  // Waits at negedges for rsp_valid, bounded to 10 cycles.
  task automatic wait_rsp(output int waited, output bit ok);
    ok = 1'b0;
    waited = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rsp_valid) begin
        ok = 1'b1;
        waited = i + 1;
        break;
      end
    end
  endtask

  initial begin
    int  waited;
    bit  ok;
    logic [3:0] exp_ids;

    rst_n     = 1'b0;
    req_valid = 2'b11;
    req_op    = 2'b00;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b1;

    // Reset state: no grant even with both requesters valid.
    #12;
    check("rst_ready", 64'(req_ready), 64'd0);
    check("rst_rsp_vld", 64'(rsp_valid), 64'd0);
    check("rst_rsp_id", 64'(rsp_id), 64'd0);
    check("rst_result", rsp_result, 64'd0);
    check("rst_cc", 64'(rsp_cc), 64'd0);
    req_valid = 2'b00;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_ready", 64'(req_ready), 64'd0);

    // Arbitration: both valid continuously for 4 ops; result = id + 1.
`ifdef ALU_SHARE_RR_EN
    exp_ids = 4'b1010;
`else
    exp_ids = 4'b0000;
`endif
    req_a = {64'd2, 64'd1};
    req_b = '0;
    req_op = 2'b00;
    req_valid = 2'b11;
    #1;
    check("arb_first_grant", 64'(req_ready), 64'd1);
    for (int k = 0; k < 4; k++) begin
      wait_rsp(waited, ok);
      check("arb_rsp_seen", 64'(ok), 64'd1);
      check("arb_gap", 64'(waited), (k == 0) ? 64'd2 : 64'd3);
      check("arb_id", 64'(rsp_id), 64'(exp_ids[k]));
      check("arb_result", rsp_result, exp_ids[k] ? 64'd2 : 64'd1);
      if (k == 3) req_valid = 2'b00;
    end
    @(negedge clk);
    check("arb_end", 64'(rsp_valid), 64'd0);

    // Directed arithmetic vectors.
    do_op("add5_7", 1'b0, 1'b0, 64'd5, 64'd7, 64'd12, 3'b000);
    do_op("sub7_7", 1'b1, 1'b1, 64'd7, 64'd7, 64'd0, 3'b100);
    do_op("sub0_1", 1'b1, 1'b1, 64'd0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 3'b010);
    do_op("add_ovf", 1'b0, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1,
          64'h8000_0000_0000_0000, 3'b011);
    do_op("sub_ovf", 1'b0, 1'b1, 64'h8000_0000_0000_0000, 64'd1,
          64'h7FFF_FFFF_FFFF_FFFF, 3'b001);
    do_op("add_carry", 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 3'b100);

    // Stall: rsp_ready low for 5 cycles in RESP while requester 1 waits.
    @(negedge clk);
    rsp_ready   = 1'b0;
    req_valid   = 2'b01;
    req_op[0]   = 1'b1;
    req_a[63:0] = 64'd10;
    req_b[63:0] = 64'd3;
    @(negedge clk);
    req_valid = 2'b10;
    @(negedge clk);
    check("stall_vld0", 64'(rsp_valid), 64'd1);
    check("stall_res0", rsp_result, 64'd7);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("stall_vld", 64'(rsp_valid), 64'd1);
      check("stall_res", rsp_result, 64'd7);
      check("stall_cc", 64'(rsp_cc), 64'd0);
      check("stall_id", 64'(rsp_id), 64'd0);
      check("stall_rdy", 64'(req_ready), 64'd0);
    end
    req_valid = 2'b00;
    rsp_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("stall_single", 64'(rsp_valid), 64'd0);
    end

    // Reset pulsed during EXEC abandons the op; next grant goes to requester 0.
    @(negedge clk);
    req_valid   = 2'b01;
    req_op      = 2'b00;
    req_a[63:0] = 64'd3;
    req_b[63:0] = 64'd4;
    @(negedge clk);
    rst_n       = 1'b0;
    req_valid   = 2'b11;
    req_a[63:0] = 64'd20;
    req_b[63:0] = 64'd1;
    #1;
    check("mid_rst_vld", 64'(rsp_valid), 64'd0);
    check("mid_rst_res", rsp_result, 64'd0);
    check("mid_rst_cc", 64'(rsp_cc), 64'd0);
    check("mid_rst_id", 64'(rsp_id), 64'd0);
    check("mid_rst_rdy", 64'(req_ready), 64'd0);
    @(negedge clk);
    check("mid_rst_hold_vld", 64'(rsp_valid), 64'd0);
    rst_n = 1'b1;
    #1;
    check("post_rst_grant", 64'(req_ready), 64'd1);
    @(negedge clk);
    req_valid = 2'b00;
    @(negedge clk);
    check("post_rst_vld", 64'(rsp_valid), 64'd1);
    check("post_rst_id", 64'(rsp_id), 64'd0);
    check("post_rst_res", rsp_result, 64'd21);
    @(negedge clk);
    check("post_rst_done", 64'(rsp_valid), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_share_scheduler.md
ALU_SHARE_SCHEDULER -- requirements
Module: alu_share_scheduler

Interface
REQ-001 SHALL have parameter WIDTH, default 64, operand/result width in bits.
REQ-002 SHALL have parameter NREQ, fixed at 2, number of requesters.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port req_valid  input  2  per-requester request valid (bit i = requester i).
REQ-006 SHALL have port req_ready  output  2  per-requester accept strobe.
REQ-007 SHALL have port req_op  input  2  per-requester op (0 = add A+B, 1 = subtract A-B).
REQ-008 SHALL have port req_a  input  2*WIDTH  operand A, requester i in bits [i*WIDTH +: WIDTH].
REQ-009 SHALL have port req_b  input  2*WIDTH  operand B, same packing.
REQ-010 SHALL have port rsp_valid  output  1  result valid.
REQ-011 SHALL have port rsp_ready  input  1  result consumer ready.
REQ-012 SHALL have port rsp_id  output  1  index of requester owning the result.
REQ-013 SHALL have port rsp_result  output  WIDTH  sum or difference, modulo 2^WIDTH.
REQ-014 SHALL have port rsp_cc  output  3  condition codes {ZF, SF, OF}.

Function
REQ-015 SHALL share one add/subtract unit between both requesters, at most one operation in flight.
REQ-016 SHALL implement FSM IDLE -> EXEC -> RESP -> IDLE.
REQ-017 In IDLE, SHALL assert req_ready for exactly the granted requester when any req_valid is high; transfer occurs when valid and ready are both high; FSM goes to EXEC and captures op, A, B, id.
REQ-018 In EXEC (one cycle), SHALL register result and flags from the shared unit and go to RESP.
REQ-019 In RESP, SHALL hold rsp_valid high with stable rsp_id, rsp_result, rsp_cc until rsp_ready is high; on that edge, SHALL return to IDLE.
REQ-020 Latency: acceptance at edge N gives rsp_valid high during cycle N+2; back-to-back throughput one op per 3 cycles with rsp_ready held high.
REQ-021 req_ready SHALL be low in EXEC and RESP; a new grant is not issued in the cycle rsp handshake completes.
REQ-022 ZF = result==0; SF = result[WIDTH-1]; OF for add = A,B same sign and result sign differs; OF for sub = A,B differing sign and result sign differs from A.
REQ-023 Carry out SHALL be discarded.
REQ-024 Requests SHALL not be dropped: a requester left waiting keeps valid high and is served in a later IDLE.

Reset
REQ-025 While rst_n low: FSM = IDLE, req_ready = 0, rsp_valid = 0, rsp_id = 0, rsp_result = 0, rsp_cc = 0, priority pointer = requester 0.
REQ-026 Reset asserted mid-operation SHALL abandon the op with no response; first grant after release follows REQ-027/028 from pointer 0.

Configuration
REQ-027 With ALU_SHARE_RR_EN defined: round-robin; after a grant to requester i, requester 1-i has priority in the next IDLE; when both valid they SHALL alternate.
REQ-028 Without ALU_SHARE_RR_EN: fixed priority, requester 0 always wins when both valid; no priority pointer state.

Structure
REQ-029 Shared package SHALL hold op encodings (ALU_OP_ADD = 0, ALU_OP_SUB = 1), FSM state enum, and cc bit positions (ZF = 2, SF = 1, OF = 0).
REQ-030 Shared unit SHALL be sub-module alu_addsub_core (combinational: op, A, B -> result, OF); ZF/SF SHALL be derived in the scheduler.

Verification
REQ-031 Req0 add A=5, B=7, rsp_ready=1 -> rsp_valid at cycle N+2, result 12, cc 3'b000, rsp_id 0.
REQ-032 Req1 sub A=7, B=7 -> result 0, cc 3'b100; sub A=0, B=1 -> result all ones, cc 3'b010.
REQ-033 Add A=0x7FFF_FFFF_FFFF_FFFF, B=1 -> result 0x8000_0000_0000_0000, cc 3'b011; sub A=0x8000_0000_0000_0000, B=1 -> cc 3'b001.
REQ-034 Both valid continuously for 4 ops: RR_EN -> rsp_id 0,1,0,1; without -> 0,0,0,0.
REQ-035 rsp_ready low for 5 cycles in RESP -> outputs stable, req_ready 0 throughout, single response.
REQ-036 rst_n pulsed low during EXEC -> no rsp_valid, all outputs 0, next grant to requester 0.
